// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
// The parameters here size the 8x8 register file that the reader walks.
package reg_dump_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_NUM_REGS  = 8;
    localparam int DEF_READ_WAIT = 1;
    localparam int COUNT_W       = DEF_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Control, register-file read/snoop and output stream signals of the dump reader.
// The master modport is the reader's view; slave is the surrounding logic.
interface reg_dump_reader_if #(
    parameter int DATA_W = reg_dump_pkg::DEF_DATA_W,
    parameter int ADDR_W = reg_dump_pkg::DEF_ADDR_W
);
    logic              START;
    logic [ADDR_W-1:0] START_ADDR;
    logic [ADDR_W:0]   COUNT;
    logic              ABORT;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] REG_DATA;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [ADDR_W-1:0] OUT_ADDR;
    logic [DATA_W-1:0] OUT_DATA;
    logic              BUSY;
    logic              DONE;

    modport master (
        input  START, START_ADDR, COUNT, ABORT, REG_DATA, WR_EN, WR_ADDR, OUT_READY,
        output RD_ADDR, OUT_VALID, OUT_ADDR, OUT_DATA, BUSY, DONE
    );

    modport slave (
        output START, START_ADDR, COUNT, ABORT, REG_DATA, WR_EN, WR_ADDR, OUT_READY,
        input  RD_ADDR, OUT_VALID, OUT_ADDR, OUT_DATA, BUSY, DONE
    );
endinterface

// File: rtl/reg_dump_addr_ctr.sv
// Read-address walker: wrapping address incrementer plus remaining-register down-counter.
// A zero or oversize count loads a full-file walk so no register is ever revisited.
module reg_dump_addr_ctr #(
    parameter int ADDR_W   = reg_dump_pkg::DEF_ADDR_W,
    parameter int NUM_REGS = reg_dump_pkg::DEF_NUM_REGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_count,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              last
);
    localparam int CW = ADDR_W + 1;

    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     remaining_q;
    logic [CW-1:0]     load_sat;

    assign load_sat = (load_count == '0 || load_count > CW'(NUM_REGS)) ? CW'(NUM_REGS) : load_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (load) begin
            addr_q      <= load_addr;
            remaining_q <= load_sat;
        end else if (step) begin
            addr_q      <= (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
        end
    end

    assign rd_addr = addr_q;
    assign last    = (remaining_q == CW'(1));

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a range of register-file entries through one read port and streams {addr, data}
// beats over valid/ready, re-settling the read whenever the write port hits the open address.
module reg_dump_reader import reg_dump_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int READ_WAIT = DEF_READ_WAIT
) (
    input  logic              CLK,
    input  logic              RESET,
    reg_dump_reader_if.master bus
);
    localparam int WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              done_q, done_d;
    logic              ld, stp, last;
    logic [ADDR_W-1:0] rd_addr;
    logic              hazard;

    reg_dump_addr_ctr #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_ctr (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (ld),
        .load_addr  (bus.START_ADDR),
        .load_count (bus.COUNT),
        .step       (stp),
        .rd_addr    (rd_addr),
        .last       (last)
    );

    // A write landing on the address being read means REG_DATA is not yet trustworthy.
    assign hazard = bus.WR_EN && (bus.WR_ADDR == rd_addr);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            wait_q  <= '0;
            valid_q <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        valid_d = valid_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        stp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    ld      = 1'b1;
                    wait_d  = WAIT_W'(READ_WAIT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (hazard) begin
                    wait_d = WAIT_W'(READ_WAIT);
                end else if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    odata_d = bus.REG_DATA;
                    oaddr_d = rd_addr;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // An abort wins over completion: a beat taken on the abort edge still gets no DONE.
                if (bus.ABORT) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.OUT_READY) begin
                    valid_d = 1'b0;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stp     = 1'b1;
                        wait_d  = WAIT_W'(READ_WAIT);
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.RD_ADDR   = rd_addr;
    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_ADDR  = oaddr_q;
    assign bus.OUT_DATA  = odata_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench: register file modelled with a one-cycle registered read, expected
// beats derived from start address, count and a shadow copy of the register contents.
module tb_reg_dump_reader;

    logic CLK = 1'b0;
    logic RESET;
    logic [7:0] wr_data;
    logic [7:0] rf [8];
    logic [7:0] model [8];
    logic [10:0] beats [$];
    int done_cnt = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    reg_dump_reader_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    reg_dump_reader #(
        .DATA_W    (8),
        .ADDR_W    (3),
        .NUM_REGS  (8),
        .READ_WAIT (1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Register file: write on the edge, read data settles one edge after the address.
    always @(posedge CLK) begin
        if (bus.WR_EN) rf[bus.WR_ADDR] <= wr_data;
        bus.REG_DATA <= rf[bus.RD_ADDR];
    end

    always @(posedge CLK) begin
        if (bus.OUT_VALID && bus.OUT_READY) beats.push_back({bus.OUT_ADDR, bus.OUT_DATA});
        if (bus.DONE) done_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input int a, input logic [7:0] d);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = 3'(a);
        wr_data     = d;
        tick();
        bus.WR_EN   = 1'b0;
        model[a]    = d;
    endtask

    task automatic start_dump(input int sa, input int cnt);
        bus.START      = 1'b1;
        bus.START_ADDR = 3'(sa);
        bus.COUNT      = 4'(cnt);
        tick();
        bus.START      = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int b = 0;
        while (!bus.OUT_VALID && b < 20) begin
            tick();
            b++;
        end
        check(tag, {31'd0, bus.OUT_VALID}, 32'd1);
    endtask

    task automatic compare_beats(input string tag, input int sa, input int cnt);
        int n;
        int a;
        n = (cnt == 0 || cnt > 8) ? 8 : cnt;
        check({tag, "_nbeats"}, beats.size(), n);
        for (int k = 0; k < n && k < beats.size(); k++) begin
            a = (sa + k) % 8;
            check({tag, "_beat"}, {21'd0, beats[k]}, {21'd0, 3'(a), model[a]});
        end
    endtask

    task automatic finish_dump(input string tag, input bit rnd, input int d0, input int sa, input int cnt);
        int b = 0;
        while (done_cnt == d0 && b < 200) begin
            bus.OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            b++;
        end
        bus.OUT_READY = 1'b1;
        tick();
        tick();
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_idle"}, {31'd0, bus.BUSY}, 32'd0);
        compare_beats(tag, sa, cnt);
    endtask

    initial begin
        int d0, sa, cnt;
        RESET          = 1'b0;
        bus.START      = 1'b0;
        bus.START_ADDR = '0;
        bus.COUNT      = '0;
        bus.ABORT      = 1'b0;
        bus.WR_EN      = 1'b0;
        bus.WR_ADDR    = '0;
        bus.OUT_READY  = 1'b1;
        wr_data        = '0;
        tick();
        tick();
        check("rst_outs", {8'd0, bus.RD_ADDR, bus.OUT_ADDR, bus.OUT_DATA},  32'd0);
        check("rst_flags", {29'd0, bus.OUT_VALID, bus.BUSY, bus.DONE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Full dump with first-beat latency
        for (int i = 0; i < 8; i++) write_reg(i, 8'(i * 8'h11));
        beats.delete();
        d0 = done_cnt;
        start_dump(0, 0);
        check("t1_busy", {30'd0, bus.BUSY, bus.OUT_VALID}, 32'd2);
        tick();
        check("t1_valid_early", {31'd0, bus.OUT_VALID}, 32'd0);
        tick();
        check("t1_first_beat", {20'd0, bus.OUT_VALID, bus.OUT_ADDR, bus.OUT_DATA}, {20'd0, 1'b1, 3'd0, 8'h00});
        finish_dump("t1", 1'b0, d0, 0, 0);
        check("t1_done_low", {31'd0, bus.DONE}, 32'd0);

        // Wrap-around
        beats.delete();
        d0 = done_cnt;
        start_dump(6, 4);
        finish_dump("t2", 1'b0, d0, 6, 4);

        // Backpressure on beat 2
        beats.delete();
        d0 = done_cnt;
        bus.OUT_READY = 1'b0;
        start_dump(0, 4);
        for (int k = 0; k < 4; k++) begin
            wait_valid("t3_valid");
            check("t3_addr", {29'd0, bus.OUT_ADDR}, k);
            if (k == 2) begin
                repeat (5) begin
                    tick();
                    check("t3_hold", {20'd0, bus.OUT_VALID, bus.OUT_ADDR, bus.OUT_DATA}, {20'd0, 1'b1, 3'd2, model[2]});
                end
            end
            bus.OUT_READY = 1'b1;
            tick();
            bus.OUT_READY = 1'b0;
        end
        check("t3_done", {31'd0, bus.DONE}, 32'd1);
        finish_dump("t3", 1'b0, d0, 0, 4);

        // Write hazard on the open address, then a write elsewhere
        beats.delete();
        d0 = done_cnt;
        bus.OUT_READY = 1'b0;
        start_dump(3, 1);
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd3; wr_data = 8'hA5;
        tick();
        bus.WR_EN = 1'b0;
        model[3] = 8'hA5;
        tick();
        check("t4_delayed", {31'd0, bus.OUT_VALID}, 32'd0);
        tick();
        check("t4_late_beat", {23'd0, bus.OUT_VALID, bus.OUT_DATA}, {23'd0, 1'b1, 8'hA5});
        finish_dump("t4a", 1'b0, d0, 3, 1);
        beats.delete();
        d0 = done_cnt;
        bus.OUT_READY = 1'b0;
        start_dump(4, 1);
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd5; wr_data = 8'h3C;
        tick();
        bus.WR_EN = 1'b0;
        model[5] = 8'h3C;
        tick();
        check("t4_no_delay", {23'd0, bus.OUT_VALID, bus.OUT_DATA}, {23'd0, 1'b1, model[4]});
        finish_dump("t4b", 1'b0, d0, 4, 1);

        // Abort while a beat is stalled
        beats.delete();
        d0 = done_cnt;
        bus.OUT_READY = 1'b0;
        start_dump(0, 3);
        wait_valid("t5_valid");
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        check("t5_abort", {29'd0, bus.OUT_VALID, bus.BUSY, bus.DONE}, 32'd0);
        tick();
        tick();
        check("t5_no_done", done_cnt - d0, 0);
        beats.delete();
        d0 = done_cnt;
        bus.OUT_READY = 1'b1;
        start_dump(2, 2);
        finish_dump("t5_restart", 1'b0, d0, 2, 2);

        // Async reset mid-dump
        d0 = done_cnt;
        start_dump(0, 0);
        repeat (5) tick();
        #2 RESET = 1'b0;
        #1;
        check("t6_rst_outs", {8'd0, bus.RD_ADDR, bus.OUT_ADDR, bus.OUT_DATA}, 32'd0);
        check("t6_rst_flags", {29'd0, bus.OUT_VALID, bus.BUSY, bus.DONE}, 32'd0);
        #2 RESET = 1'b1;
        tick();
        tick();
        check("t6_no_done", done_cnt - d0, 0);

        // START while busy is ignored
        beats.delete();
        d0 = done_cnt;
        start_dump(0, 2);
        start_dump(5, 1);
        finish_dump("t6_busy_start", 1'b0, d0, 0, 2);

        // ABORT together with START in IDLE
        bus.ABORT = 1'b1;
        start_dump(1, 1);
        bus.ABORT = 1'b0;
        check("t6_abort_start", {31'd0, bus.BUSY}, 32'd0);
        tick();
        tick();
        check("t6_abort_start_valid", {31'd0, bus.OUT_VALID}, 32'd0);

        // Randomized contents, ranges and backpressure
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < 8; r++) write_reg(r, 8'($urandom_range(0, 255)));
            sa  = $urandom_range(0, 7);
            cnt = $urandom_range(0, 15);
            beats.delete();
            d0 = done_cnt;
            start_dump(sa, cnt);
            finish_dump("rnd", 1'b1, d0, sa, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
